mem_port_arbiter: RTL and testbench

//   Shares one single-ported synchronous memory between the pipeline's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported synchronous memory between the fetch port and the data port,
// with at most one read in flight and a bounded data-priority streak.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LAT        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Handshake: a request is held with its payload until ready; ready is combinational and
  // marks the issue cycle, so req & ready is the transfer and the memory strobe in one.
  localparam logic [3:0] MAX_B    = 4'(MAX_DATA_BURST);
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_owner_dm, w_owner_nxt;
  logic [2:0]        r_lat_cnt, w_lat_nxt;
  logic [3:0]        r_streak, w_streak_nxt;
  logic              r_if_rvalid, r_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata, r_dm_rdata;
  logic              w_dm_win, w_if_win, w_done;

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner_dm;
    w_lat_nxt    = r_lat_cnt;
    w_streak_nxt = r_streak;
    w_dm_win     = 1'b0;
    w_if_win     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Data side is the older instruction, but yields once the streak limit is hit.
        w_dm_win = dm_req & ~(if_req & (r_streak == MAX_B));
        w_if_win = if_req & ~w_dm_win;
        if (w_dm_win) begin
          w_streak_nxt = (r_streak == MAX_B) ? r_streak : r_streak + 4'd1;
        end else if (w_if_win || !dm_req) begin
          w_streak_nxt = 4'd0;
        end
        if ((w_dm_win && !dm_we) || w_if_win) begin
          w_state_nxt = ST_WAIT;
          w_owner_nxt = w_dm_win;
          w_lat_nxt   = LAT_INIT;
        end
      end
      ST_WAIT: begin
        if (r_lat_cnt == 3'd0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_lat_nxt = r_lat_cnt - 3'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner_dm  <= 1'b0;
      r_lat_cnt   <= 3'd0;
      r_streak    <= 4'd0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner_dm  <= w_owner_nxt;
      r_lat_cnt   <= w_lat_nxt;
      r_streak    <= w_streak_nxt;
      r_if_rvalid <= w_done & ~r_owner_dm;
      r_dm_rvalid <= w_done & r_owner_dm;
      if (w_done && !r_owner_dm) r_if_rdata <= mem_rdata;
      if (w_done && r_owner_dm)  r_dm_rdata <= mem_rdata;
    end
  end

  assign if_ready  = w_if_win;
  assign dm_ready  = w_dm_win;
  assign if_stall  = if_req & ~w_if_win;
  assign dm_stall  = dm_req & ~w_dm_win;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = w_if_win | w_dm_win;
  assign mem_we    = w_dm_win & dm_we;
  assign mem_addr  = w_dm_win ? dm_addr : (w_if_win ? if_addr : '0);
  assign mem_wdata = (w_dm_win && dm_we) ? dm_wdata : '0;
  assign busy      = (r_state == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model with MEM_LAT pipeline, per-port expected queues,
// directed timing scenarios and a random hold-until-ready phase.
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata, mem_rdata_l1;
  logic          if_ready, if_rvalid, if_stall, dm_ready, dm_rvalid, dm_stall;
  logic          mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ready_l1, if_rvalid_l1, if_stall_l1, dm_ready_l1, dm_rvalid_l1, dm_stall_l1;
  logic          mem_en_l1, mem_we_l1, busy_l1;
  logic [DW-1:0] if_rdata_l1, dm_rdata_l1, mem_wdata_l1;
  logic [AW-1:0] mem_addr_l1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DATA_BURST(BURST)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Second instance with single-cycle memory latency, sharing the request inputs.
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_DATA_BURST(BURST)) dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_l1), .if_rvalid(if_rvalid_l1),
    .if_rdata(if_rdata_l1), .if_stall(if_stall_l1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready_l1), .dm_rvalid(dm_rvalid_l1), .dm_rdata(dm_rdata_l1),
    .dm_stall(dm_stall_l1),
    .mem_en(mem_en_l1), .mem_we(mem_we_l1), .mem_addr(mem_addr_l1), .mem_wdata(mem_wdata_l1),
    .mem_rdata(mem_rdata_l1), .busy(busy_l1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] if_exp_q[$];
  logic [DW-1:0] dm_exp_q[$];
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] rd_pipe [1:LAT];
  logic [DW-1:0] rd_l1;
  logic          acc_if, acc_dm;

  function automatic logic [DW-1:0] mem_init(input int i);
    if (i == 16) return 32'h00500093;
    return {8'(i), 8'(~i), 8'(i ^ 8'h5a), 8'h93};
  endfunction

  // Memory model: read data for an issue edge appears LAT cycles later.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    rd_pipe[1] <= mem[mem_addr[7:0]];
    for (int i = 2; i <= LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    rd_l1 <= mem[mem_addr_l1[7:0]];
  end
  assign mem_rdata    = rd_pipe[LAT];
  assign mem_rdata_l1 = rd_l1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: push on accepted reads, pop on response pulses.
  always @(negedge clk) begin
    if (reset) begin
      if_exp_q.delete();
      dm_exp_q.delete();
    end else begin
      if (if_exp_q.size() == 0) check("if_rvalid_unexpected", if_rvalid, 0);
      else if (if_rvalid) check("if_rdata_sb", if_rdata, if_exp_q.pop_front());
      if (dm_exp_q.size() == 0) check("dm_rvalid_unexpected", dm_rvalid, 0);
      else if (dm_rvalid) check("dm_rdata_sb", dm_rdata, dm_exp_q.pop_front());
      check("ready_exclusive", if_ready & dm_ready, 0);
      check("ready_in_wait", busy & (if_ready | dm_ready), 0);
      if (if_ready) if_exp_q.push_back(mem[if_addr[7:0]]);
      if (dm_ready && !dm_we) dm_exp_q.push_back(mem[dm_addr[7:0]]);
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    repeat (n) next_cyc();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, {if_ready, if_rvalid, if_stall, dm_ready, dm_rvalid, dm_stall,
                          mem_en, mem_we, busy}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    idle_inputs();
    acc_if = 1'b0;
    acc_dm = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    to_neg();
    check_quiet("rst");
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);

    // Single fetch: issue c0, busy c1-c2, response c3.
    next_cyc(); if_req = 1'b1; if_addr = 32'h10;
    to_neg();
    check("t1_if_ready", if_ready, 1);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 32'h10);
    check("t1_busy_c0", busy, 0);
    next_cyc(); if_req = 1'b0; to_neg(); check("t1_busy_c1", busy, 1);
    next_cyc(); to_neg(); check("t1_busy_c2", busy, 1);
    next_cyc(); to_neg();
    check("t1_if_rvalid_c3", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 32'h00500093);
    check("t1_busy_c3", busy, 0);
    next_cyc(); to_neg();
    check("t1_if_rvalid_c4", if_rvalid, 0);
    check("t1_if_rdata_hold", if_rdata, 32'h00500093);

    // Data read beats fetch; fetch granted in the response cycle.
    next_cyc();
    if_req = 1'b1; if_addr = 32'h14; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    to_neg();
    check("t2_dm_ready", dm_ready, 1);
    check("t2_if_ready_c0", if_ready, 0);
    check("t2_if_stall_c0", if_stall, 1);
    check("t2_mem_addr", mem_addr, 32'h40);
    next_cyc(); dm_req = 1'b0; to_neg(); check("t2_if_stall_c1", if_stall, 1);
    next_cyc(); to_neg(); check("t2_if_stall_c2", if_stall, 1);
    next_cyc(); to_neg();
    check("t2_dm_rvalid_c3", dm_rvalid, 1);
    check("t2_dm_rdata", dm_rdata, mem_init(8'h40));
    check("t2_if_ready_c3", if_ready, 1);
    next_cyc(); if_req = 1'b0; to_neg(); check("t2_if_rvalid_c4", if_rvalid, 0);
    next_cyc(); to_neg(); check("t2_if_rvalid_c5", if_rvalid, 0);
    next_cyc(); to_neg(); check("t2_if_rvalid_c6", if_rvalid, 1);

    // Data write: no response, pending fetch granted next cycle; read it back.
    next_cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h24;
    to_neg();
    check("t3_dm_ready", dm_ready, 1);
    check("t3_mem_en_we", {mem_en, mem_we}, 2'b11);
    check("t3_mem_addr", mem_addr, 32'h20);
    check("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("t3_if_ready_c0", if_ready, 0);
    next_cyc(); dm_req = 1'b0; dm_we = 1'b0; to_neg();
    check("t3_if_ready_c1", if_ready, 1);
    check("t3_mem_we_c1", mem_we, 0);
    check("t3_mem_wdata_c1", mem_wdata, 0);
    next_cyc(); if_req = 1'b0;
    next_cyc();
    next_cyc(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; to_neg();
    check("t3_rd_ready", dm_ready, 1);
    check("t3_if_rvalid", if_rvalid, 1);
    next_cyc(); dm_req = 1'b0;
    next_cyc();
    next_cyc(); to_neg();
    check("t3_rd_rvalid", dm_rvalid, 1);
    check("t3_rd_rdata", dm_rdata, 32'hDEADBEEF);

    // Both held: BURST data writes, one fetch, then the fetch's wait cycles.
    next_cyc();
    if_req = 1'b1; if_addr = 32'h18;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h0BADF00D;
    for (int k = 0; k < 2 * (BURST + 1 + LAT); k++) begin
      int p;
      p = k % (BURST + 1 + LAT);
      to_neg();
      check("t4_grant", {if_ready, dm_ready},
            (p < BURST) ? 2'b01 : ((p == BURST) ? 2'b10 : 2'b00));
      check("t4_dm_stall", dm_stall, (p < BURST) ? 0 : 1);
      next_cyc();
    end
    // Streak saturates while fetch is absent, so a fetch arriving late wins at once.
    if_req = 1'b0;
    for (int k = 0; k < BURST + 2; k++) begin
      to_neg(); check("t4_dm_alone", dm_ready, 1); next_cyc();
    end
    if_req = 1'b1;
    to_neg();
    check("t4_sat_grant", {if_ready, dm_ready}, 2'b10);
    next_cyc(); drain(3);

    // Reset while a fetch is outstanding: response abandoned.
    if_req = 1'b1; if_addr = 32'h1c;
    to_neg(); check("t5_issue", if_ready, 1);
    next_cyc(); if_req = 1'b0; reset = 1'b1; to_neg(); check("t5_busy_c1", busy, 1);
    next_cyc(); reset = 1'b0; to_neg(); check_quiet("t5_c2");
    next_cyc(); to_neg(); check("t5_no_rvalid_c3", if_rvalid, 0);
    next_cyc(); to_neg(); check("t5_no_rvalid_c4", if_rvalid, 0);
    next_cyc(); if_req = 1'b1; if_addr = 32'h1c;
    to_neg(); check("t5b_issue", if_ready, 1);
    next_cyc(); reset = 1'b1;
    next_cyc(); reset = 1'b0; to_neg(); check("t5b_reaccept", if_ready, 1);
    next_cyc(); drain(3);

    // Requester withdrawing during WAIT issues nothing.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    to_neg(); check("t7_dm_ready", dm_ready, 1);
    next_cyc(); dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h48;
    to_neg(); check("t7_if_stall", if_stall, 1);
    next_cyc(); if_req = 1'b0; to_neg(); check("t7_mem_en_c2", mem_en, 0);
    next_cyc(); to_neg();
    check("t7_dm_rvalid", dm_rvalid, 1);
    check("t7_no_issue", {mem_en, busy}, 2'b00);
    next_cyc(); drain(3);

    // Single-cycle latency instance: fetch every second cycle, response meets next grant.
    if_req = 1'b1; if_addr = 32'h30;
    for (int k = 0; k < 8; k++) begin
      to_neg();
      check("t6_if_ready_l1", if_ready_l1, (k % 2 == 0) ? 1 : 0);
      if (k > 0) check("t6_if_rvalid_l1", if_rvalid_l1, (k % 2 == 0) ? 1 : 0);
      if (k >= 2 && k % 2 == 0) check("t6_if_rdata_l1", if_rdata_l1, mem_init(8'h30));
      next_cyc();
    end
    drain(4);

    // Random traffic; requests held until accepted.
    for (int k = 0; k < 80; k++) begin
      if (!if_req || acc_if) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 32'($urandom_range(0, 63)) << 2;
      end
      if (!dm_req || acc_dm) begin
        dm_req   = 1'($urandom_range(0, 1));
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 32'($urandom_range(0, 63)) << 2;
        dm_wdata = $urandom;
      end
      to_neg();
      acc_if = if_ready;
      acc_dm = dm_ready;
      next_cyc();
    end
    drain(6);
    to_neg();
    check("if_queue_empty", if_exp_q.size(), 0);
    check("dm_queue_empty", dm_exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
